// File: rtl/spi_reg_controller.sv
// ---------------------------------------------------------------------------
// spi_reg_controller
//
// This block sits behind a byte-level SPI slave and turns SPI frames into
// register-bus accesses. The first byte of a frame is the command:
// bit 7 selects read (1) or write (0), and bits 6:0 give the start address.
// Each later byte then writes to, or reads from, an address that goes up by
// one after every byte.
//
// Ports
//   clk           system clock; every flop uses its rising edge
//   rst           synchronous reset, active-high
//   ssel          SPI slave select, active-low
//   byteReceived  one-clk pulse when a byte has been shifted in
//   receivedData  the completed byte; valid while byteReceived=1
//   dataNeeded    the SPI slave is loading dataToSend
//   dataToSend    the next byte to shift out on MISO
//   reg_addr      register-bus address
//   reg_wdata     register-bus write data
//   reg_we        register write strobe, one clk wide
//   reg_re        register read strobe, one clk wide
//   reg_rdata     register read data, valid one clk after reg_re
//   frame_done    one-clk pulse when ssel deasserts after an active frame
//   frame_bytes   byte count of the last frame (saturates at 255)
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | no frame active; waiting for ssel low (after ssel high)
// CMD        | shifting in the command byte
// WRITE      | each received byte is written, then addr advances
// READ_FETCH | reg_re issued, waiting for reg_rdata, loading tx_buf
// READ       | tx_buf holds read data; the next byte advances addr
// ---------------------------------------------------------------------------
module spi_reg_controller #(
   parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ssel,
   input  logic       byteReceived,
   input  logic [7:0] receivedData,
   input  logic       dataNeeded,
   output logic [7:0] dataToSend,
   output logic [6:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       frame_done,
   output logic [7:0] frame_bytes
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      CMD        = 3'd1,
      WRITE      = 3'd2,
      READ_FETCH = 3'd3,
      READ       = 3'd4
   } state_t;

   state_t     state_q;
   logic [6:0] addr_q;
   logic [7:0] tx_buf_q;
   logic [7:0] count_q;
   logic [7:0] frame_bytes_q;
   logic [6:0] reg_addr_q;
   logic [7:0] reg_wdata_q;
   logic       reg_we_q;
   logic       reg_re_q;
   logic       frame_done_q;
   // Set once ssel has been seen high. After a reset, a new frame is only
   // accepted after ssel goes high and then low again.
   logic       armed_q;
   // Fetch phase: 0 issue reg_re, 1 read data in flight, 2 capture.
   logic [1:0] fetch_ph_q;

   // dataNeeded is not needed here. Because the clock runs at least 8x SCK,
   // tx_buf is always ready before the slave loads it.
   logic unused_dataneeded;
   assign unused_dataneeded = dataNeeded;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         addr_q        <= 7'd0;
         tx_buf_q      <= 8'd0;
         count_q       <= 8'd0;
         frame_bytes_q <= 8'd0;
         reg_addr_q    <= 7'd0;
         reg_wdata_q   <= 8'd0;
         reg_we_q      <= 1'b0;
         reg_re_q      <= 1'b0;
         frame_done_q  <= 1'b0;
         armed_q       <= 1'b0;
         fetch_ph_q    <= 2'd0;
      end else begin
         reg_we_q     <= 1'b0;
         reg_re_q     <= 1'b0;
         frame_done_q <= 1'b0;
         if (ssel) begin
            // End of frame wins over everything, including a byte that
            // completes in the same clk. Any read still in flight is dropped.
            armed_q    <= 1'b1;
            fetch_ph_q <= 2'd0;
            if (state_q != IDLE) begin
               frame_done_q  <= 1'b1;
               frame_bytes_q <= count_q;
            end
            state_q <= IDLE;
         end else begin
            if (byteReceived && (state_q != IDLE) && (count_q != 8'hFF))
               count_q <= count_q + 8'd1;
            case (state_q)
               IDLE: begin
                  if (armed_q) begin
                     state_q <= CMD;
                     count_q <= 8'd0;
                  end
               end
               CMD: begin
                  if (byteReceived) begin
                     addr_q     <= receivedData[6:0];
                     fetch_ph_q <= 2'd0;
                     state_q    <= receivedData[7] ? READ_FETCH : WRITE;
                  end
               end
               WRITE: begin
                  if (byteReceived) begin
                     reg_we_q    <= 1'b1;
                     reg_addr_q  <= addr_q;
                     reg_wdata_q <= receivedData;
                     addr_q      <= addr_q + 7'd1;
                  end
               end
               READ_FETCH: begin
                  case (fetch_ph_q)
                     2'd0: begin
                        reg_re_q   <= 1'b1;
                        reg_addr_q <= addr_q;
                        fetch_ph_q <= 2'd1;
                     end
                     2'd1: fetch_ph_q <= 2'd2;
                     default: begin
                        tx_buf_q   <= reg_rdata;
                        fetch_ph_q <= 2'd0;
                        state_q    <= READ;
                     end
                  endcase
               end
               READ: begin
                  if (byteReceived) begin
                     addr_q     <= addr_q + 7'd1;
                     fetch_ph_q <= 2'd0;
                     state_q    <= READ_FETCH;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      dataToSend = STATUS_BYTE;
      case (state_q)
         WRITE:            dataToSend = 8'h00;
         READ_FETCH, READ: dataToSend = tx_buf_q;
         default:          dataToSend = STATUS_BYTE;
      endcase
   end

   assign reg_addr    = reg_addr_q;
   assign reg_wdata   = reg_wdata_q;
   assign reg_we      = reg_we_q;
   assign reg_re      = reg_re_q;
   assign frame_done  = frame_done_q;
   assign frame_bytes = frame_bytes_q;

endmodule

// File: tb/tb_spi_reg_controller.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_controller
//
// The bench plays two parts: the byte-level SPI slave and a 128-byte register
// file. For each frame, the stimulus code works out the expected write
// strobes, read strobes, MISO bytes and frame byte count from the frame
// contents and a model copy of the register file. It queues those values.
// A monitor on the falling edge pops the queues and compares them whenever
// the DUT presents a strobe, a frame_done or a MISO load.
// ---------------------------------------------------------------------------
module tb_spi_reg_controller;

   localparam logic [7:0] STATUS = 8'hA5;

   logic       clk = 1'b0;
   logic       rst;
   logic       ssel;
   logic       byteReceived;
   logic [7:0] receivedData;
   logic       dataNeeded;
   logic [7:0] dataToSend;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       frame_done;
   logic [7:0] frame_bytes;

   always #5 clk = ~clk;

   spi_reg_controller #(.STATUS_BYTE(STATUS)) dut (
      .clk          (clk),
      .rst          (rst),
      .ssel         (ssel),
      .byteReceived (byteReceived),
      .receivedData (receivedData),
      .dataNeeded   (dataNeeded),
      .dataToSend   (dataToSend),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .reg_we       (reg_we),
      .reg_re       (reg_re),
      .reg_rdata    (reg_rdata),
      .frame_done   (frame_done),
      .frame_bytes  (frame_bytes)
   );

   // Register file on the DUT's bus. It can also be preloaded through a
   // back-door port.
   logic [7:0] mem [128];
   logic       bd_we;
   logic [6:0] bd_addr;
   logic [7:0] bd_data;

   always @(posedge clk) begin
      if (bd_we)       mem[bd_addr]  <= bd_data;
      else if (reg_we) mem[reg_addr] <= reg_wdata;
      if (reg_re)      reg_rdata     <= mem[reg_addr];
   end

   // Reference model and scoreboard queues.
   logic [7:0]  model_mem [128];
   logic [7:0]  frm [$];
   logic [14:0] exp_we [$];
   logic [6:0]  exp_re [$];
   logic [7:0]  exp_fd [$];
   logic [7:0]  exp_miso [$];

   logic       miso_flag;
   logic [7:0] miso_val;
   logic       chk_reset;
   logic       end_check;
   int         n_cmp  = 0;
   int         n_fail = 0;

   task automatic report(input bit ok, input string msg);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s", msg);
      end
   endtask

   always @(negedge clk) begin
      logic [14:0] e_we;
      logic [6:0]  e_re;
      logic [7:0]  e_b;
      if (reg_we || reg_re)
         report(!(reg_we && reg_re), "we_re_overlap: got both strobes, expected at most one");
      if (reg_we) begin
         if (exp_we.size() == 0)
            report(1'b0, $sformatf("we_unexpected: got addr=%h data=%h, expected no write", reg_addr, reg_wdata));
         else begin
            e_we = exp_we.pop_front();
            report({reg_addr, reg_wdata} == e_we,
                   $sformatf("we: got addr=%h data=%h, expected addr=%h data=%h",
                             reg_addr, reg_wdata, e_we[14:8], e_we[7:0]));
         end
      end
      if (reg_re) begin
         if (exp_re.size() == 0)
            report(1'b0, $sformatf("re_unexpected: got addr=%h, expected no read", reg_addr));
         else begin
            e_re = exp_re.pop_front();
            report(reg_addr == e_re, $sformatf("re: got addr=%h, expected addr=%h", reg_addr, e_re));
         end
      end
      if (frame_done) begin
         if (exp_fd.size() == 0)
            report(1'b0, $sformatf("fd_unexpected: got frame_done bytes=%0d, expected none", frame_bytes));
         else begin
            e_b = exp_fd.pop_front();
            report(frame_bytes == e_b, $sformatf("frame_bytes: got %0d, expected %0d", frame_bytes, e_b));
         end
      end
      if (miso_flag) begin
         if (exp_miso.size() == 0)
            report(1'b0, $sformatf("miso_unexpected: got %h, expected no load", miso_val));
         else begin
            e_b = exp_miso.pop_front();
            report(miso_val == e_b, $sformatf("miso: got %h, expected %h", miso_val, e_b));
         end
      end
      if (chk_reset) begin
         report(reg_we == 1'b0,      $sformatf("rst_we: got %b, expected 0", reg_we));
         report(reg_re == 1'b0,      $sformatf("rst_re: got %b, expected 0", reg_re));
         report(frame_done == 1'b0,  $sformatf("rst_fd: got %b, expected 0", frame_done));
         report(frame_bytes == 8'd0, $sformatf("rst_fb: got %h, expected 00", frame_bytes));
         report(reg_addr == 7'd0,    $sformatf("rst_addr: got %h, expected 00", reg_addr));
         report(reg_wdata == 8'd0,   $sformatf("rst_wdata: got %h, expected 00", reg_wdata));
         report(dataToSend == STATUS, $sformatf("rst_miso: got %h, expected %h", dataToSend, STATUS));
      end
      if (end_check) begin
         report(exp_we.size() == 0,   $sformatf("we_missing: got %0d left, expected 0", exp_we.size()));
         report(exp_re.size() == 0,   $sformatf("re_missing: got %0d left, expected 0", exp_re.size()));
         report(exp_fd.size() == 0,   $sformatf("fd_missing: got %0d left, expected 0", exp_fd.size()));
         report(exp_miso.size() == 0, $sformatf("miso_missing: got %0d left, expected 0", exp_miso.size()));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // The slave loads its shift register; the monitor checks the sampled byte.
   task automatic do_load();
      miso_val   = dataToSend;
      miso_flag  = 1'b1;
      dataNeeded = 1'b1;
      tick(1);
      miso_flag  = 1'b0;
      dataNeeded = 1'b0;
   endtask

   task automatic xfer_byte(input logic [7:0] b, input bit with_rise);
      do_load();
      tick(10);
      receivedData = b;
      byteReceived = 1'b1;
      if (with_rise) ssel = 1'b1;
      tick(1);
      byteReceived = 1'b0;
      tick(4);
   endtask

   // Runs the frame held in frm. If partial is set, ssel rises partway
   // through one more byte. If collide is set, the last byte completes in
   // the same clk as the ssel rise.
   task automatic run_frame(input bit partial, input bit collide);
      int         n;
      int         nb;
      int         idx;
      logic [6:0] a;
      logic       is_rd;
      n     = frm.size();
      nb    = collide ? n - 1 : n;
      a     = frm[0][6:0];
      is_rd = frm[0][7];
      exp_miso.push_back(STATUS);
      for (int k = 1; k < n + (partial ? 1 : 0); k++) begin
         idx = (int'(a) + k - 1) % 128;
         exp_miso.push_back(is_rd ? model_mem[idx] : 8'h00);
      end
      if (is_rd) begin
         for (int j = 0; j < nb; j++) exp_re.push_back(7'((int'(a) + j) % 128));
      end else begin
         for (int k = 1; k < nb; k++) begin
            idx = (int'(a) + k - 1) % 128;
            exp_we.push_back({7'(idx), frm[k]});
            model_mem[idx] = frm[k];
         end
      end
      exp_fd.push_back(8'((nb > 255) ? 255 : nb));

      ssel = 1'b0;
      tick(2);
      for (int k = 0; k < n; k++) xfer_byte(frm[k], collide && (k == n - 1));
      if (partial) begin
         do_load();
         tick(8);
      end else begin
         tick(2);
      end
      ssel = 1'b1;
      tick(4);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      rst          = 1'b1;
      ssel         = 1'b1;
      byteReceived = 1'b0;
      receivedData = 8'h00;
      dataNeeded   = 1'b0;
      miso_flag    = 1'b0;
      miso_val     = 8'h00;
      chk_reset    = 1'b0;
      end_check    = 1'b0;
      bd_we        = 1'b0;
      bd_addr      = 7'd0;
      bd_data      = 8'd0;
      tick(2);
      for (int i = 0; i < 128; i++) begin
         bd_we        = 1'b1;
         bd_addr      = 7'(i);
         bd_data      = 8'($urandom);
         model_mem[i] = bd_data;
         tick(1);
      end
      bd_we     = 1'b0;
      chk_reset = 1'b1;
      tick(1);
      chk_reset = 1'b0;
      rst       = 1'b0;
      tick(3);

      // Basic write, then preload 5/6, then burst read 5..7.
      frm = '{8'h05, 8'h11, 8'h22};        run_frame(1'b0, 1'b0);
      frm = '{8'h05, 8'h3C, 8'h4D};        run_frame(1'b0, 1'b0);
      frm = '{8'h85, 8'($urandom), 8'($urandom)}; run_frame(1'b0, 1'b0);
      // Address wrap on write.
      frm = '{8'h7F, 8'h9A, 8'hBC};        run_frame(1'b0, 1'b0);
      // Read across the wrap point.
      frm = '{8'hFE, 8'h00, 8'h00, 8'h00}; run_frame(1'b0, 1'b0);
      // ssel rises partway through the second byte.
      frm = '{8'h10};                      run_frame(1'b1, 1'b0);
      // Byte completes in the same clk as the ssel rise.
      frm = '{8'h20, 8'h55, 8'h66};        run_frame(1'b0, 1'b1);

      for (int it = 0; it < 14; it++) begin
         int  n;
         bit  part;
         bit  coll;
         n = $urandom_range(1, 6);
         frm.delete();
         for (int k = 0; k < n; k++) frm.push_back(8'($urandom));
         part = ($urandom_range(0, 3) == 0);
         coll = !part && (n >= 2) && ($urandom_range(0, 3) == 0);
         run_frame(part, coll);
      end

      // Reset in the middle of a read burst, with ssel held low afterwards.
      exp_miso.push_back(STATUS);
      exp_re.push_back(7'h03);
      exp_miso.push_back(model_mem[3]);
      ssel = 1'b0;
      tick(2);
      xfer_byte(8'h83, 1'b0);
      do_load();
      tick(4);
      rst = 1'b1;
      tick(1);
      chk_reset = 1'b1;
      tick(1);
      chk_reset = 1'b0;
      rst       = 1'b0;
      tick(2);
      for (int k = 0; k < 3; k++) begin
         exp_miso.push_back(STATUS);
         xfer_byte((k == 0) ? 8'h05 : 8'($urandom), 1'b0);
      end
      ssel = 1'b1;
      tick(4);
      frm = '{8'h30, 8'hC3};               run_frame(1'b0, 1'b0);

      // Long write burst: the count saturates and the address wraps repeatedly.
      frm.delete();
      frm.push_back(8'h40);
      for (int k = 0; k < 299; k++) frm.push_back(8'($urandom));
      run_frame(1'b0, 1'b0);

      tick(5);
      end_check = 1'b1;
      tick(1);
      end_check = 1'b0;
      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
